// File: rtl/operand_fetch.sv
// Operand fetch: an 8-entry register file with one read port, and an IDLE/RD_A/RD_B FSM.
// The FSM reads operand A and then operand B through that shared port.
module operand_fetch #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_num,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [2:0]        rn,
    input  logic [2:0]        rm,
    input  logic [1:0]        shift_in,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [1:0]        shift_out
);

    typedef enum logic [1:0] {IDLE, RD_A, RD_B} state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [8];
    logic [2:0]        rn_lat;
    logic [2:0]        rm_lat;
    logic [1:0]        shift_lat;
    logic [2:0]        rd_idx;
    logic [DATA_W-1:0] rd_data;

    // Single read port, shared between the two read states.
    always_comb begin
        rd_idx  = (state == RD_B) ? rm_lat : rn_lat;
        rd_data = regs[rd_idx];
    end

    assign busy = (state != IDLE);

    // Reads sample the array before this edge's write lands, so there is no bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_num] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            shift_out <= 2'b00;
            rn_lat    <= '0;
            rm_lat    <= '0;
            shift_lat <= 2'b00;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rn_lat    <= rn;
                        rm_lat    <= rm;
                        shift_lat <= shift_in;
                        state     <= RD_A;
                    end
                end
                RD_A: begin
                    a_out <= rd_data;
                    state <= RD_B;
                end
                RD_B: begin
                    b_out     <= rd_data;
                    shift_out <= shift_lat;
                    valid     <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch.
// Inputs are driven and outputs checked 1 ns after each rising edge.
module tb_operand_fetch;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [2:0]        wr_num = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic [2:0]        rn = '0;
    logic [2:0]        rm = '0;
    logic [1:0]        shift_in = '0;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [1:0]        shift_out;

    int checks = 0;
    int errors = 0;

    operand_fetch #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
        .start(start), .rn(rn), .rm(rm), .shift_in(shift_in), .busy(busy), .valid(valid),
        .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_num = idx; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        logic [2:0]        fr_rn [3];
        logic [2:0]        fr_rm [3];
        logic [DATA_W-1:0] fr_a  [3];
        logic [DATA_W-1:0] fr_b  [3];

        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a", a_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_shift", shift_out, 0);

        // Fetch R0/R0 right after reset
        start = 1'b1; rn = 0; rm = 0; shift_in = 2'b00;
        tick();
        start = 1'b0;
        chk("f0_busy_k", busy, 1);
        chk("f0_valid_k", valid, 0);
        tick();
        chk("f0_busy_k1", busy, 1);
        chk("f0_a", a_out, 0);
        chk("f0_valid_k1", valid, 0);
        tick();
        chk("f0_valid_k2", valid, 1);
        chk("f0_busy_k2", busy, 0);
        chk("f0_b", b_out, 0);
        tick();
        chk("f0_valid_drop", valid, 0);

        // R3/R5 fetch; indices and shift change after acceptance
        wr(3, 16'hF0F0);
        wr(5, 16'h0001);
        start = 1'b1; rn = 3; rm = 5; shift_in = 2'b11;
        tick();
        start = 1'b0; rn = 0; rm = 0; shift_in = 2'b00;
        tick();
        chk("f1_a", a_out, 16'hF0F0);
        chk("f1_valid_k1", valid, 0);
        tick();
        chk("f1_b", b_out, 16'h0001);
        chk("f1_shift", shift_out, 2'b11);
        chk("f1_valid", valid, 1);
        tick();
        chk("f1_a_hold", a_out, 16'hF0F0);
        chk("f1_shift_hold", shift_out, 2'b11);

        // Write to R2 on the RD_A edge: A sees the old value, B the new one
        wr(2, 16'h1234);
        start = 1'b1; rn = 2; rm = 2; shift_in = 2'b01;
        tick();
        start = 1'b0;
        wr(2, 16'hABCD);
        chk("rdw_a_old", a_out, 16'h1234);
        tick();
        chk("rdw_b_new", b_out, 16'hABCD);
        chk("rdw_valid", valid, 1);

        // start held high: one fetch per 3 cycles
        wr(1, 16'h1111);
        wr(4, 16'h4444);
        wr(6, 16'h6666);
        fr_rn[0] = 1; fr_rm[0] = 4; fr_a[0] = 16'h1111; fr_b[0] = 16'h4444;
        fr_rn[1] = 6; fr_rm[1] = 3; fr_a[1] = 16'h6666; fr_b[1] = 16'hF0F0;
        fr_rn[2] = 2; fr_rm[2] = 5; fr_a[2] = 16'hABCD; fr_b[2] = 16'h0001;
        start = 1'b1; shift_in = 2'b10;
        for (int i = 0; i < 3; i++) begin
            rn = fr_rn[i]; rm = fr_rm[i];
            tick();
            chk("b2b_valid_accept", valid, 0);
            chk("b2b_busy_accept", busy, 1);
            rn = 3'd7; rm = 3'd0;
            tick();
            chk("b2b_a", a_out, fr_a[i]);
            chk("b2b_valid_rda", valid, 0);
            tick();
            chk("b2b_b", b_out, fr_b[i]);
            chk("b2b_valid", valid, 1);
        end
        start = 1'b0;
        tick();
        chk("b2b_end_valid", valid, 0);
        chk("b2b_end_busy", busy, 0);

        // rn == rm == 7
        wr(7, 16'h8001);
        start = 1'b1; rn = 7; rm = 7; shift_in = 2'b10;
        tick();
        start = 1'b0;
        tick();
        chk("same_a", a_out, 16'h8001);
        tick();
        chk("same_b", b_out, 16'h8001);
        chk("same_shift", shift_out, 2'b10);
        chk("same_valid", valid, 1);

        // Reset in RD_B aborts the fetch and overrides a concurrent write
        tick();
        start = 1'b1; rn = 3; rm = 5; shift_in = 2'b01;
        tick();
        start = 1'b0;
        tick();
        chk("abort_in_rdb", busy, 1);
        reset = 1'b1; wr_en = 1'b1; wr_num = 3; wr_data = 16'hFFFF;
        tick();
        reset = 1'b0; wr_en = 1'b0;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_a", a_out, 0);
        chk("abort_b", b_out, 0);
        chk("abort_shift", shift_out, 0);
        tick();
        chk("abort_valid_next", valid, 0);

        // Registers cleared by reset, including the one written on the reset edge
        start = 1'b1; rn = 3; rm = 7; shift_in = 2'b00;
        tick();
        start = 1'b0;
        tick();
        chk("clr_a", a_out, 0);
        tick();
        chk("clr_b", b_out, 0);
        chk("clr_valid", valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter: DATA_W, default 16, width of register-file entries and operand outputs.
REQ-002 SHALL have clock: clk  input  1  rising-edge clock; one clock domain only.
REQ-003 SHALL have reset: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: wr_en  input  1  register-file write enable.
REQ-005 SHALL have port: wr_num  input  3  destination register index R0..R7.
REQ-006 SHALL have port: wr_data  input  DATA_W  write data.
REQ-007 SHALL have port: start  input  1  request an operand fetch; sampled only in IDLE.
REQ-008 SHALL have port: rn  input  3  A-operand register index.
REQ-009 SHALL have port: rm  input  3  B-operand register index.
REQ-010 SHALL have port: shift_in  input  2  shift code for the downstream shifter.
REQ-011 SHALL have port: busy  output  1  high while a fetch is in progress.
REQ-012 SHALL have port: valid  output  1  one-cycle pulse; a_out/b_out/shift_out are fresh.
REQ-013 SHALL have port: a_out  output  DATA_W  A operand register.
REQ-014 SHALL have port: b_out  output  DATA_W  B operand register; drives the shifter data input.
REQ-015 SHALL have port: shift_out  output  2  registered shift code; drives the shifter control input.

Function
REQ-016 SHALL contain eight DATA_W-bit registers R0..R7 with one write port and exactly one read port.
REQ-017 SHALL write wr_data into R[wr_num] on every rising edge with wr_en=1 and reset=0, in any FSM state.
REQ-018 SHALL implement FSM states IDLE, RD_A, RD_B.
REQ-019 IDLE with start=1: on that edge, latch rn, rm and shift_in; go to RD_A. IDLE with start=0: stay in IDLE.
REQ-020 RD_A: on the edge, a_out <= R[latched rn]; go to RD_B.
REQ-021 RD_B: on the edge, b_out <= R[latched rm]; shift_out <= latched shift code; valid <= 1; go to IDLE.
REQ-022 valid SHALL be registered and high for exactly one cycle per fetch; 0 in all other cycles.
REQ-023 Latency: start sampled at edge k gives A loaded at edge k+1, B and valid at edge k+2.
REQ-024 busy SHALL be combinational, 1 in RD_A and RD_B and 0 in IDLE.
REQ-025 start SHALL be ignored while busy=1; no queuing of requests.
REQ-026 start=1 in the cycle valid=1 SHALL be accepted (state is IDLE), allowing back-to-back fetches every 3 cycles.
REQ-027 rn, rm and shift_in changes after acceptance SHALL NOT affect the fetch in progress.
REQ-028 Read-during-write to the same register on the same edge SHALL return the pre-write value; no bypass.
REQ-029 rn == rm SHALL be legal; a_out and b_out receive that register's value as sampled at their respective edges.
REQ-030 a_out, b_out and shift_out SHALL hold their value between fetches.

Reset
REQ-031 reset=1 at an edge SHALL force state IDLE, valid=0, a_out=0, b_out=0, shift_out=2'b00 and R0..R7=0.
REQ-032 reset SHALL override wr_en and start on the same edge, and SHALL abort a fetch in RD_A or RD_B with no valid pulse.

Verification
REQ-033 Reset, then start with rn=0, rm=0, shift_in=00 -> a_out=0, b_out=0, valid pulse at edge k+2, busy=1 for 2 cycles.
REQ-034 Write R3=16'hF0F0 and R5=16'h0001; start with rn=3, rm=5, shift_in=11 -> a_out=F0F0 at k+1; b_out=0001, shift_out=11 and valid=1 at k+2.
REQ-035 R2=16'h1234; wr_en to R2 with 16'hABCD on the RD_A edge of a fetch with rn=2 -> a_out=1234, R2=ABCD afterwards.
REQ-036 start held high continuously with changing rn/rm -> exactly one fetch per 3 cycles, operands from indices sampled at acceptance, valid never high two cycles in a row.
REQ-037 reset asserted in RD_B -> no valid pulse, all outputs 0 on the next cycle, busy=0.
REQ-038 Start with rn=rm=7, R7=16'h8001, shift_in=10 -> a_out=b_out=8001, shift_out=10.
